// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer and its refill line buffer.
package fetch_ctrl_pkg;

  localparam int NUM_BEATS = 4;
  localparam int BEAT_CNT_W = $clog2(NUM_BEATS);
  localparam logic [63:0] INSTR_SIZE = 64'd4;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE     = 3'd0;
  localparam fsm_state_t ST_RUN      = 3'd1;
  localparam fsm_state_t ST_MEM_REQ  = 3'd2;
  localparam fsm_state_t ST_MEM_BEAT = 3'd3;
  localparam fsm_state_t ST_FILL     = 3'd4;

endpackage

// File: rtl/refill_line_buffer.sv
// Collects memory beats into a cacheline, first beat landing in the top slot.
module refill_line_buffer
  import fetch_ctrl_pkg::*;
#(
  parameter int NUM    = NUM_BEATS,
  parameter int BEAT_W = 64,
  parameter int CNT_W  = BEAT_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_beat_valid,
  input  logic [BEAT_W-1:0]     i_beat,
  output logic [NUM*BEAT_W-1:0] o_line,
  output logic                  o_last_beat
);

  logic [NUM*BEAT_W-1:0] r_line;
  logic [CNT_W-1:0]      r_count;

  // Shift each accepted beat in at the LSB end and count beats; wrap after the last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_line  <= '0;
      r_count <= '0;
    end else if (i_beat_valid) begin
      r_line  <= {r_line[(NUM-1)*BEAT_W-1:0], i_beat};
      r_count <= (r_count == CNT_W'(NUM-1)) ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_line      = r_line;
  assign o_last_beat = (r_count == CNT_W'(NUM-1));

endmodule

// File: rtl/icache_refill_controller.sv
// Fetch address sequencer with miss handling: stops issue, squashes, refills
// the line from memory beat by beat, writes it to the cache and replays.
module icache_refill_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int          offsetSize        = 5,
  parameter int          indexSize         = 8,
  parameter int          tagSize           = 64 - (offsetSize + indexSize),
  parameter int          cachelineSizeBits = (2 ** offsetSize) * 8,
  parameter int          beatSizeBits      = 64,
  parameter logic [63:0] resetVector       = 64'h0
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         run_i,
  input  logic                         stall_i,
  input  logic                         redirectValid_i,
  input  logic [63:0]                  redirectAddr_i,
  output logic                         fetchEnable_o,
  output logic [tagSize-1:0]           tag_o,
  output logic [indexSize-1:0]         index_o,
  output logic [offsetSize-1:0]        offset_o,
  input  logic                         missValid_i,
  input  logic [tagSize-1:0]           missTag_i,
  input  logic [indexSize-1:0]         missIndex_i,
  input  logic [offsetSize-1:0]        missOffset_i,
  output logic                         squash_o,
  output logic                         memReq_o,
  output logic [63:0]                  memAddr_o,
  input  logic                         memGrant_i,
  input  logic                         memBeatValid_i,
  input  logic [beatSizeBits-1:0]      memBeat_i,
  output logic                         cacheUpdateEnable_o,
  output logic [tagSize-1:0]           newTag_o,
  output logic [indexSize-1:0]         newIndex_o,
  output logic [cachelineSizeBits-1:0] newCacheline_o
);

  localparam int numBeats = cachelineSizeBits / beatSizeBits;
  localparam int cntW     = (numBeats > 1) ? $clog2(numBeats) : 1;

  fsm_state_t             r_state;
  logic [63:0]            r_pc;          // next address to issue
  logic [63:0]            r_issue_addr;  // address presented with fetchEnable_o
  logic                   r_fetch_en;
  logic                   r_squash;
  logic                   r_mem_req;
  logic                   r_cache_upd;
  logic [tagSize-1:0]     r_miss_tag;
  logic [indexSize-1:0]   r_miss_index;
  logic                   r_redir_pend;
  logic [63:0]            r_redir_addr;

  logic [63:0]            w_miss_addr;
  logic [63:0]            w_base_pc;
  logic [63:0]            w_res_pc;
  logic                   w_res_issue;
  logic                   w_beat_take;
  logic                   w_last_beat;
  logic                   w_lb_clear;
  logic                   w_redir_latch;
  logic                   w_redir_clear;
  logic [cachelineSizeBits-1:0] w_line;

  assign w_miss_addr = {missTag_i, missIndex_i, missOffset_i};
  // A held redirect overrides the stored PC when (re)entering RUN.
  assign w_base_pc   = r_redir_pend ? r_redir_addr : r_pc;
  assign w_beat_take = (r_state == ST_MEM_BEAT) && memBeatValid_i;
  assign w_lb_clear  = (r_state == ST_RUN) && missValid_i;

  assign w_redir_latch = redirectValid_i &&
                         (((r_state == ST_IDLE) && !run_i) ||
                          ((r_state == ST_RUN) && missValid_i) ||
                          (r_state == ST_MEM_REQ) || (r_state == ST_MEM_BEAT));
  assign w_redir_clear = (r_state == ST_FILL) || ((r_state == ST_IDLE) && run_i);

  // Decide the issue action for a cycle spent in (or entering) RUN.
  always_comb begin
    w_res_issue = 1'b0;
    w_res_pc    = w_base_pc;
    if (redirectValid_i) begin
      w_res_pc = redirectAddr_i;
    end else if (!stall_i) begin
      w_res_issue = 1'b1;
      w_res_pc    = w_base_pc + INSTR_SIZE;
    end else begin
      w_res_pc = w_base_pc;
    end
  end

  // Keep only the latest redirect seen while it cannot be applied directly.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_redir_pend <= 1'b0;
      r_redir_addr <= 64'h0;
    end else if (w_redir_latch) begin
      r_redir_pend <= 1'b1;
      r_redir_addr <= redirectAddr_i;
    end else if (w_redir_clear) begin
      r_redir_pend <= 1'b0;
    end
  end

  // Main sequencer: issue, miss capture, memory handshake, fill and resume.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= ST_IDLE;
      r_pc         <= resetVector;
      r_issue_addr <= resetVector;
      r_fetch_en   <= 1'b0;
      r_squash     <= 1'b0;
      r_mem_req    <= 1'b0;
      r_cache_upd  <= 1'b0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
    end else begin
      r_fetch_en  <= 1'b0;
      r_cache_upd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run_i) begin
            r_state    <= ST_RUN;
            r_pc       <= w_res_pc;
            r_fetch_en <= w_res_issue;
            if (w_res_issue) r_issue_addr <= w_base_pc;
          end
        end
        ST_RUN: begin
          if (missValid_i) begin
            r_state      <= ST_MEM_REQ;
            r_pc         <= w_miss_addr;
            r_miss_tag   <= missTag_i;
            r_miss_index <= missIndex_i;
            r_squash     <= 1'b1;
            r_mem_req    <= 1'b1;
          end else if (!run_i) begin
            r_state <= ST_IDLE;
            if (redirectValid_i) r_pc <= redirectAddr_i;
          end else begin
            r_pc       <= w_res_pc;
            r_fetch_en <= w_res_issue;
            if (w_res_issue) r_issue_addr <= w_base_pc;
          end
        end
        ST_MEM_REQ: begin
          if (memGrant_i) begin
            r_state   <= ST_MEM_BEAT;
            r_mem_req <= 1'b0;
          end
        end
        ST_MEM_BEAT: begin
          if (w_beat_take && w_last_beat) begin
            r_state     <= ST_FILL;
            r_cache_upd <= 1'b1;
          end
        end
        ST_FILL: begin
          r_squash <= 1'b0;
          if (run_i) begin
            r_state    <= ST_RUN;
            r_pc       <= w_res_pc;
            r_fetch_en <= w_res_issue;
            if (w_res_issue) r_issue_addr <= w_base_pc;
          end else begin
            r_state <= ST_IDLE;
            r_pc    <= redirectValid_i ? redirectAddr_i : w_base_pc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  refill_line_buffer #(
    .NUM    (numBeats),
    .BEAT_W (beatSizeBits),
    .CNT_W  (cntW)
  ) u_line_buffer (
    .i_clk        (clock_i),
    .i_rst_n      (reset_i),
    .i_clear      (w_lb_clear),
    .i_beat_valid (w_beat_take),
    .i_beat       (memBeat_i),
    .o_line       (w_line),
    .o_last_beat  (w_last_beat)
  );

  assign fetchEnable_o       = r_fetch_en;
  assign tag_o               = r_issue_addr[63 -: tagSize];
  assign index_o             = r_issue_addr[offsetSize +: indexSize];
  assign offset_o            = r_issue_addr[offsetSize-1:0];
  assign squash_o            = r_squash;
  assign memReq_o            = r_mem_req;
  assign memAddr_o           = {r_miss_tag, r_miss_index, {offsetSize{1'b0}}};
  assign cacheUpdateEnable_o = r_cache_upd;
  assign newTag_o            = r_miss_tag;
  assign newIndex_o          = r_miss_index;
  assign newCacheline_o      = w_line;

endmodule

// File: tb/tb_icache_refill_controller.sv
// Scoreboard bench: stimulus pushes expected fetches, line requests and cache
// writes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_icache_refill_controller;

  localparam int OFF_W = 5;
  localparam int IDX_W = 8;
  localparam int TAG_W = 51;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst_n;
  logic              run_i, stall_i, redir_v;
  logic [63:0]       redir_a;
  logic              fetch_en;
  logic [TAG_W-1:0]  tag_o;
  logic [IDX_W-1:0]  index_o;
  logic [OFF_W-1:0]  offset_o;
  logic              miss_v;
  logic [63:0]       miss_a;
  logic              squash, mem_req, grant, beat_v, cache_upd;
  logic [63:0]       mem_addr, beat;
  logic [TAG_W-1:0]  new_tag;
  logic [IDX_W-1:0]  new_idx;
  logic [LINE_W-1:0] new_line;

  typedef struct {
    logic [LINE_W-1:0] line;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
  } fill_t;

  logic [63:0] exp_fetch[$];
  logic [63:0] exp_req[$];
  fill_t       exp_fill[$];

  int   checks = 0;
  int   errors = 0;
  logic prev_req = 1'b0;

  icache_refill_controller #(.resetVector(64'h1000)) dut (
    .clock_i(clk), .reset_i(rst_n), .run_i(run_i), .stall_i(stall_i),
    .redirectValid_i(redir_v), .redirectAddr_i(redir_a),
    .fetchEnable_o(fetch_en), .tag_o(tag_o), .index_o(index_o), .offset_o(offset_o),
    .missValid_i(miss_v), .missTag_i(miss_a[63:13]), .missIndex_i(miss_a[12:5]),
    .missOffset_i(miss_a[4:0]), .squash_o(squash), .memReq_o(mem_req),
    .memAddr_o(mem_addr), .memGrant_i(grant), .memBeatValid_i(beat_v),
    .memBeat_i(beat), .cacheUpdateEnable_o(cache_upd), .newTag_o(new_tag),
    .newIndex_o(new_idx), .newCacheline_o(new_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_fetch_en"}, LINE_W'(fetch_en), '0);
    chk({tagname, "_squash"}, LINE_W'(squash), '0);
    chk({tagname, "_mem_req"}, LINE_W'(mem_req), '0);
    chk({tagname, "_cache_upd"}, LINE_W'(cache_upd), '0);
    chk({tagname, "_addr"}, LINE_W'({tag_o, index_o, offset_o}), LINE_W'(64'h1000));
    chk({tagname, "_new_fields"}, LINE_W'({new_tag, new_idx}), '0);
    chk({tagname, "_new_line"}, new_line, '0);
  endtask

  // Monitor: pop and compare each DUT transaction as it appears.
  always @(negedge clk) begin
    if (fetch_en) begin
      if (exp_fetch.size() == 0) begin
        chk("fetch_unexpected", LINE_W'({tag_o, index_o, offset_o}), LINE_W'(64'hDEAD));
      end else begin
        chk("fetch_addr", LINE_W'({tag_o, index_o, offset_o}), LINE_W'(exp_fetch.pop_front()));
      end
    end
    if (mem_req && !prev_req) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", LINE_W'(mem_addr), LINE_W'(64'hDEAD));
      end else begin
        chk("req_addr", LINE_W'(mem_addr), LINE_W'(exp_req.pop_front()));
      end
    end
    prev_req = mem_req;
    if (cache_upd) begin
      if (exp_fill.size() == 0) begin
        chk("fill_unexpected", LINE_W'(new_idx), LINE_W'(9'h1FF));
      end else begin
        fill_t f;
        f = exp_fill.pop_front();
        chk("fill_line", new_line, f.line);
        chk("fill_tag", LINE_W'(new_tag), LINE_W'(f.tag));
        chk("fill_index", LINE_W'(new_idx), LINE_W'(f.idx));
      end
    end
  end

  initial begin
    logic [63:0] beats_a [4];
    logic [63:0] beats_b [4];
    fill_t f;
    beats_a[0] = 64'hA0A1A2A3A4A5A6A7; beats_a[1] = 64'hB0B1B2B3B4B5B6B7;
    beats_a[2] = 64'hC0C1C2C3C4C5C6C7; beats_a[3] = 64'hD0D1D2D3D4D5D6D7;
    beats_b[0] = 64'h1111111111111111; beats_b[1] = 64'h2222222222222222;
    beats_b[2] = 64'h3333333333333333; beats_b[3] = 64'h4444444444444444;

    rst_n = 1'b0; run_i = 1'b1; stall_i = 1'b0; redir_v = 1'b0; redir_a = 64'h0;
    miss_v = 1'b0; miss_a = 64'h0; grant = 1'b0; beat_v = 1'b0; beat = 64'h0;
    tick; tick;
    chk_reset_outputs("reset");

    // Sequential issue from the reset vector.
    exp_fetch.push_back(64'h1000); exp_fetch.push_back(64'h1004); exp_fetch.push_back(64'h1008);
    rst_n = 1'b1;
    tick; tick; tick;
    run_i = 1'b0;
    tick;
    chk("idle_no_fetch", LINE_W'(fetch_en), '0);

    // Miss at 0x2040, second miss pulse ignored, stray beat before grant ignored.
    exp_fetch.push_back(64'h100C);
    run_i = 1'b1;
    tick;
    miss_v = 1'b1; miss_a = 64'h2040;
    exp_req.push_back(64'h2040);
    tick;
    chk("miss_fetch_off", LINE_W'(fetch_en), '0);
    chk("miss_squash", LINE_W'(squash), LINE_W'(1'b1));
    chk("miss_req1", LINE_W'({mem_req, mem_addr}), LINE_W'({1'b1, 64'h2040}));
    miss_a = 64'h3000;
    tick;
    miss_v = 1'b0; beat_v = 1'b1; beat = 64'hBAD0BAD0BAD0BAD0;
    chk("miss_req2", LINE_W'({mem_req, mem_addr}), LINE_W'({1'b1, 64'h2040}));
    tick;
    beat_v = 1'b0;
    chk("miss_req3", LINE_W'({mem_req, mem_addr}), LINE_W'({1'b1, 64'h2040}));
    grant = 1'b1;
    tick;
    grant = 1'b0;
    chk("req_dropped", LINE_W'(mem_req), '0);
    f.line = {beats_a[0], beats_a[1], beats_a[2], beats_a[3]};
    f.tag = TAG_W'(1); f.idx = 8'h02;
    exp_fill.push_back(f);
    exp_fetch.push_back(64'h2040);
    for (int k = 0; k < 4; k++) begin
      beat_v = 1'b1; beat = beats_a[k];
      tick;
    end
    beat_v = 1'b0;
    chk("fill_strobe", LINE_W'({cache_upd, squash, fetch_en}), LINE_W'(3'b110));
    tick;
    chk("replay_issue", LINE_W'({fetch_en, squash, cache_upd}), LINE_W'(3'b100));
    run_i = 1'b0;
    tick;

    // Redirect during the beat phase wins over the miss address on resume.
    exp_fetch.push_back(64'h2044);
    run_i = 1'b1;
    tick;
    miss_v = 1'b1; miss_a = 64'h4FE8;
    exp_req.push_back(64'h4FE0);
    tick;
    miss_v = 1'b0; grant = 1'b1;
    tick;
    grant = 1'b0;
    f.line = {beats_b[0], beats_b[1], beats_b[2], beats_b[3]};
    f.tag = TAG_W'(2); f.idx = 8'h7F;
    exp_fill.push_back(f);
    exp_fetch.push_back(64'h8000);
    for (int k = 0; k < 4; k++) begin
      beat_v = 1'b1; beat = beats_b[k];
      redir_v = (k == 1); redir_a = 64'h8000;
      tick;
    end
    beat_v = 1'b0; redir_v = 1'b0;
    tick;
    chk("resume_redirect", LINE_W'({fetch_en, tag_o, index_o, offset_o}), LINE_W'({1'b1, 64'h8000}));
    run_i = 1'b0;
    tick;

    // Reset after two beats drops the refill.
    exp_fetch.push_back(64'h8004);
    run_i = 1'b1;
    tick;
    miss_v = 1'b1; miss_a = 64'h6000;
    exp_req.push_back(64'h6000);
    tick;
    miss_v = 1'b0; grant = 1'b1;
    tick;
    grant = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat_v = 1'b1; beat = beats_a[k];
      tick;
    end
    chk("pre_reset_squash", LINE_W'(squash), LINE_W'(1'b1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tick;
    rst_n = 1'b1; run_i = 1'b0;
    tick; tick;
    beat_v = 1'b0;
    chk("late_beats_ignored", LINE_W'({cache_upd, squash, new_line}), '0);

    // Wrap at the top of the address space and stall hold.
    run_i = 1'b1; redir_v = 1'b1; redir_a = 64'hFFFF_FFFF_FFFF_FFFC;
    tick;
    chk("redirect_no_issue", LINE_W'(fetch_en), '0);
    redir_v = 1'b0;
    exp_fetch.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_fetch.push_back(64'h0);
    tick; tick;
    stall_i = 1'b1;
    tick;
    chk("stall_hold1", LINE_W'({fetch_en, tag_o, index_o, offset_o}), '0);
    tick;
    chk("stall_hold2", LINE_W'({fetch_en, tag_o, index_o, offset_o}), '0);
    stall_i = 1'b0;
    exp_fetch.push_back(64'h4);
    tick;
    run_i = 1'b0;
    tick; tick;

    chk("fetch_queue_drained", LINE_W'(exp_fetch.size()), '0);
    chk("req_queue_drained", LINE_W'(exp_req.size()), '0);
    chk("fill_queue_drained", LINE_W'(exp_fill.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
